data_ram_arbiter: RTL and testbench

//  Shares the single-port DataRAM between two requesters: port A (CPU load/store

---
 rtl/data_ram_arbiter_if.sv | 51 +++++
 rtl/data_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_data_ram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if
//   Bundles the two requester ports (A: CPU load/store, B: DMA/debug loader),
//   the single-port DataRAM strobes/buses and the Busy flag.
//   slave  : arbiter side (drives Ack/RData/Err, RAM strobes, Busy)
//   master : environment side (requesters and the RAM itself)
interface data_ram_arbiter_if;
  // Port A
  logic        A_Req;
  logic        A_Write;
  logic [15:0] A_Addr;
  logic [15:0] A_WData;
  logic        A_Ack;
  logic [15:0] A_RData;
  logic        A_Err;
  // Port B
  logic        B_Req;
  logic        B_Write;
  logic [15:0] B_Addr;
  logic [15:0] B_WData;
  logic        B_Ack;
  logic [15:0] B_RData;
  logic        B_Err;
  // DataRAM
  logic [15:0] DataAddress;
  logic        ReadMem;
  logic        WriteMem;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  // Status
  logic        Busy;

  modport slave (
    input  A_Req, A_Write, A_Addr, A_WData,
    output A_Ack, A_RData, A_Err,
    input  B_Req, B_Write, B_Addr, B_WData,
    output B_Ack, B_RData, B_Err,
    output DataAddress, ReadMem, WriteMem, DataIn,
    input  DataOut,
    output Busy
  );

  modport master (
    output A_Req, A_Write, A_Addr, A_WData,
    input  A_Ack, A_RData, A_Err,
    output B_Req, B_Write, B_Addr, B_WData,
    input  B_Ack, B_RData, B_Err,
    input  DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut,
    input  Busy
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single-port DataRAM between port A and port B. A request is
//   sampled in IDLE, the winner's command is registered, the RAM is strobed for
//   exactly one ACCESS cycle from that register, and a one-cycle Ack (with
//   RData/Err) is returned to the owner in ACK. Out-of-range addresses skip the
//   access and go straight to ACK with Err=1.
// Ports
//   CLK    system clock (posedge)
//   RST_N  asynchronous active-low reset
//   bus    data_ram_arbiter_if.slave: A_*/B_* requester ports, DataAddress/
//          ReadMem/WriteMem/DataIn/DataOut RAM port, Busy
// Parameters
//   DEPTH  number of RAM words; addresses >= DEPTH return Err
//   A_PRIO 1 = A wins every tie, 0 = round-robin on ties
module data_ram_arbiter #(
  parameter int DEPTH  = 256,
  parameter int A_PRIO = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  data_ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Range bound held in 17 bits so DEPTH = 65536 means "every address valid"
  // and the compare always sees the full 16-bit address.
  localparam logic [16:0] DEPTH_W = (DEPTH >= 65536) ? 17'h10000 : 17'(DEPTH);

  state_t      state_q, state_d;
  port_t       last_q,  last_d;
  port_t       own_q,   own_d;
  logic        wr_q,    wr_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic        a_win;
  logic [15:0] sel_addr;
  logic        in_range;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      last_q  <= PORT_B;
      own_q   <= PORT_A;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    // A wins when B is idle, when A has fixed priority, or when B had the last grant.
    a_win    = bus.A_Req && (!bus.B_Req || (A_PRIO != 0) || (last_q == PORT_B));
    sel_addr = a_win ? bus.A_Addr : bus.B_Addr;
    in_range = ({1'b0, sel_addr} < DEPTH_W);

    case (state_q)
      S_IDLE: begin
        if (bus.A_Req || bus.B_Req) begin
          own_d   = a_win ? PORT_A : PORT_B;
          last_d  = a_win ? PORT_A : PORT_B;
          wr_d    = a_win ? bus.A_Write : bus.B_Write;
          addr_d  = sel_addr;
          wdata_d = a_win ? bus.A_WData : bus.B_WData;
          rdata_d = '0;
          if (in_range) begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end
        end
      end
      S_ACCESS: begin
        if (!wr_q) begin
          rdata_d = bus.DataOut;
        end
        err_d   = 1'b0;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // RAM side is decoded from registered state only, so reset removes the
  // strobes immediately and requester inputs never reach the RAM directly.
  assign bus.DataAddress = (state_q == S_ACCESS) ? addr_q : '0;
  assign bus.ReadMem     = (state_q == S_ACCESS) && !wr_q;
  assign bus.WriteMem    = (state_q == S_ACCESS) && wr_q;
  assign bus.DataIn      = ((state_q == S_ACCESS) && wr_q) ? wdata_q : '0;

  assign bus.A_Ack   = (state_q == S_ACK) && (own_q == PORT_A);
  assign bus.B_Ack   = (state_q == S_ACK) && (own_q == PORT_B);
  assign bus.A_RData = rdata_q;
  assign bus.B_RData = rdata_q;
  assign bus.A_Err   = err_q;
  assign bus.B_Err   = err_q;

  assign bus.Busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb_data_ram_arbiter
//   Two arbiters (round-robin and A-priority) each with its own 256-word RAM.
//   A transaction-level model (mem_model plus ordering/latency rules) supplies
//   every expected value.
module tb_data_ram_arbiter;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  data_ram_arbiter_if if0 ();
  data_ram_arbiter_if if1 ();

  data_ram_arbiter #(.DEPTH(256), .A_PRIO(0)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(if0));
  data_ram_arbiter #(.DEPTH(256), .A_PRIO(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1));

  logic [15:0] ram0 [0:255];
  logic [15:0] ram1 [0:255];
  logic [15:0] mem_model [0:255];

  assign if0.DataOut = ram0[if0.DataAddress[7:0]];
  assign if1.DataOut = ram1[if1.DataAddress[7:0]];
  always @(posedge CLK) if (if0.WriteMem) ram0[if0.DataAddress[7:0]] <= if0.DataIn;
  always @(posedge CLK) if (if1.WriteMem) ram1[if1.DataAddress[7:0]] <= if1.DataIn;

  int passed = 0;
  int total  = 0;

  task automatic drv0(input bit pb, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (!pb) begin if0.A_Req = r; if0.A_Write = w; if0.A_Addr = a; if0.A_WData = d; end
    else     begin if0.B_Req = r; if0.B_Write = w; if0.B_Addr = a; if0.B_WData = d; end
  endtask

  task automatic drv1(input bit pb, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (!pb) begin if1.A_Req = r; if1.A_Write = w; if1.A_Addr = a; if1.A_WData = d; end
    else     begin if1.B_Req = r; if1.B_Write = w; if1.B_Addr = a; if1.B_WData = d; end
  endtask

  task automatic do_reset();
    drv0(0, 0, 0, '0, '0); drv0(1, 0, 0, '0, '0);
    drv1(0, 0, 0, '0, '0); drv1(1, 0, 0, '0, '0);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if0.A_Ack !== 1'b0) $display("FAIL rst_a_ack: got %0h expected 0", if0.A_Ack); else passed++;
    total++; if (if0.B_Ack !== 1'b0) $display("FAIL rst_b_ack: got %0h expected 0", if0.B_Ack); else passed++;
    total++; if (if0.A_Err !== 1'b0) $display("FAIL rst_err: got %0h expected 0", if0.A_Err); else passed++;
    total++; if (if0.A_RData !== 16'h0) $display("FAIL rst_rdata: got %0h expected 0", if0.A_RData); else passed++;
    total++; if (if0.DataAddress !== 16'h0) $display("FAIL rst_addr: got %0h expected 0", if0.DataAddress); else passed++;
    total++; if (if0.DataIn !== 16'h0) $display("FAIL rst_datain: got %0h expected 0", if0.DataIn); else passed++;
    total++; if ({if0.ReadMem, if0.WriteMem} !== 2'b00) $display("FAIL rst_strobes: got %0b expected 00", {if0.ReadMem, if0.WriteMem}); else passed++;
    total++; if (if0.Busy !== 1'b0) $display("FAIL rst_busy: got %0h expected 0", if0.Busy); else passed++;
    total++; if ({if1.Busy, if1.A_Ack, if1.B_Ack} !== 3'b000) $display("FAIL rst_dut1: got %0b expected 000", {if1.Busy, if1.A_Ack, if1.B_Ack}); else passed++;
  endtask

  task automatic test_write_read();
    int wm_cycles = 0;
    int lat = 0;
    bit got = 0;
    drv0(0, 1, 1, 16'h0010, 16'hBEEF);
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge CLK);
      if (if0.WriteMem) begin
        wm_cycles++;
        total++; if ({if0.DataAddress, if0.DataIn} !== {16'h0010, 16'hBEEF})
          $display("FAIL wr_bus: got %0h expected %0h", {if0.DataAddress, if0.DataIn}, {16'h0010, 16'hBEEF}); else passed++;
      end
      if (if0.A_Ack) begin got = 1; lat = c; drv0(0, 0, 0, '0, '0); end
    end
    mem_model[16'h10] = 16'hBEEF;
    total++; if (lat != 2) $display("FAIL wr_latency: got %0d expected 2", lat); else passed++;
    total++; if (wm_cycles != 1) $display("FAIL wr_strobe_cycles: got %0d expected 1", wm_cycles); else passed++;
    total++; if (if0.A_RData !== 16'h0) $display("FAIL wr_rdata: got %0h expected 0", if0.A_RData); else passed++;
    total++; if (ram0[16'h10] !== 16'hBEEF) $display("FAIL wr_ram: got %0h expected beef", ram0[16'h10]); else passed++;
    @(negedge CLK);
    drv0(0, 1, 0, 16'h0010, 16'h0);
    got = 0; lat = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        total++; if (if0.ReadMem !== 1'b1) $display("FAIL rd_strobe: got %0h expected 1", if0.ReadMem); else passed++;
      end
      if (if0.A_Ack) begin
        got = 1; lat = c;
        total++; if (if0.A_RData !== mem_model[16'h10]) $display("FAIL rd_data: got %0h expected %0h", if0.A_RData, mem_model[16'h10]); else passed++;
        drv0(0, 0, 0, '0, '0);
      end
    end
    total++; if (lat != 2) $display("FAIL rd_latency: got %0d expected 2", lat); else passed++;
    @(negedge CLK);
  endtask

  task automatic test_round_robin();
    logic [15:0] aa [4];
    logic [15:0] ba [4];
    int ia = 0, ib = 0, nacks = 0, last_t = 0;
    bit exp_b = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin aa[i] = 16'($urandom_range(0, 255)); ba[i] = 16'($urandom_range(0, 255)); end
    drv0(0, 1, 0, aa[0], '0);
    drv0(1, 1, 0, ba[0], '0);
    for (int c = 0; c < 60 && nacks < 8; c++) begin
      @(negedge CLK);
      if (if0.A_Ack || if0.B_Ack) begin
        bit gb;
        gb = if0.B_Ack;
        total++; if (gb !== exp_b) $display("FAIL rr_order: got port %0d expected port %0d", gb, exp_b); else passed++;
        total++; if (if0.A_Ack && if0.B_Ack) $display("FAIL rr_excl: got both acks expected one"); else passed++;
        if (nacks > 0) begin
          total++; if (c - last_t != 3) $display("FAIL rr_spacing: got %0d expected 3", c - last_t); else passed++;
        end
        if (gb) begin
          total++; if (if0.B_RData !== mem_model[ba[ib][7:0]]) $display("FAIL rr_b_data: got %0h expected %0h", if0.B_RData, mem_model[ba[ib][7:0]]); else passed++;
          ib++;
          if (ib < 4) drv0(1, 1, 0, ba[ib], '0); else drv0(1, 0, 0, '0, '0);
        end else begin
          total++; if (if0.A_RData !== mem_model[aa[ia][7:0]]) $display("FAIL rr_a_data: got %0h expected %0h", if0.A_RData, mem_model[aa[ia][7:0]]); else passed++;
          ia++;
          if (ia < 4) drv0(0, 1, 0, aa[ia], '0); else drv0(0, 0, 0, '0, '0);
        end
        exp_b = !exp_b; last_t = c; nacks++;
      end
    end
    total++; if (nacks != 8) $display("FAIL rr_count: got %0d expected 8", nacks); else passed++;
    drv0(0, 0, 0, '0, '0); drv0(1, 0, 0, '0, '0);
    @(negedge CLK);
  endtask

  task automatic test_prio();
    int a_acks = 0, b_acks = 0, last_t = 0, bad_gap = 0;
    logic [15:0] ad;
    do_reset();
    ad = 16'($urandom_range(0, 255));
    drv1(0, 1, 0, ad, '0);
    drv1(1, 1, 0, 16'h0005, '0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (if1.B_Ack) b_acks++;
      if (if1.A_Ack) begin
        if (a_acks > 0 && c - last_t != 3) bad_gap++;
        total++; if (if1.A_RData !== ram1[ad[7:0]]) $display("FAIL prio_a_data: got %0h expected %0h", if1.A_RData, ram1[ad[7:0]]); else passed++;
        a_acks++; last_t = c;
        ad = 16'($urandom_range(0, 255));
        if (c >= 29) begin drv1(0, 0, 0, '0, '0); drv1(1, 0, 0, '0, '0); end
        else drv1(0, 1, 0, ad, '0);
      end
    end
    total++; if (a_acks != 10) $display("FAIL prio_a_count: got %0d expected 10", a_acks); else passed++;
    total++; if (b_acks != 0) $display("FAIL prio_b_starve: got %0d expected 0", b_acks); else passed++;
    total++; if (bad_gap != 0) $display("FAIL prio_spacing: got %0d bad gaps expected 0", bad_gap); else passed++;
    drv1(0, 0, 0, '0, '0); drv1(1, 0, 0, '0, '0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_out_of_range();
    logic [15:0] addrs [3];
    bit          errs  [3];
    addrs[0] = 16'h0100; errs[0] = 1;
    addrs[1] = 16'h1010; errs[1] = 1;
    addrs[2] = 16'h00FF; errs[2] = 0;
    for (int k = 0; k < 3; k++) begin
      int lat = 0, strobes = 0;
      bit got = 0;
      drv0(1, 1, 0, addrs[k], '0);
      for (int c = 1; c <= 10 && !got; c++) begin
        @(negedge CLK);
        if (if0.ReadMem || if0.WriteMem) strobes++;
        if (if0.B_Ack) begin
          got = 1; lat = c;
          total++; if (if0.B_Err !== errs[k]) $display("FAIL oor_err: got %0h expected %0h", if0.B_Err, errs[k]); else passed++;
          total++; if (if0.B_RData !== (errs[k] ? 16'h0 : mem_model[addrs[k][7:0]]))
            $display("FAIL oor_rdata: got %0h expected %0h", if0.B_RData, (errs[k] ? 16'h0 : mem_model[addrs[k][7:0]])); else passed++;
          drv0(1, 0, 0, '0, '0);
        end
      end
      total++; if (lat != (errs[k] ? 1 : 2)) $display("FAIL oor_latency: got %0d expected %0d", lat, (errs[k] ? 1 : 2)); else passed++;
      total++; if (strobes != (errs[k] ? 0 : 1)) $display("FAIL oor_strobes: got %0d expected %0d", strobes, (errs[k] ? 0 : 1)); else passed++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    drv0(0, 1, 1, 16'h0020, 16'h1234);
    @(negedge CLK);
    total++; if (if0.WriteMem !== 1'b1) $display("FAIL mid_wr_strobe: got %0h expected 1", if0.WriteMem); else passed++;
    #1 RST_N = 1'b0;
    #1;
    total++; if (if0.WriteMem !== 1'b0) $display("FAIL mid_wr_abort: got %0h expected 0", if0.WriteMem); else passed++;
    total++; if (if0.Busy !== 1'b0) $display("FAIL mid_wr_busy: got %0h expected 0", if0.Busy); else passed++;
    drv0(0, 0, 0, '0, '0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) begin @(negedge CLK); if (if0.A_Ack || if0.B_Ack) acks++; end
    total++; if (acks != 0) $display("FAIL mid_wr_noack: got %0d expected 0", acks); else passed++;
    total++; if (ram0[16'h20] !== mem_model[16'h20]) $display("FAIL mid_wr_mem: got %0h expected %0h", ram0[16'h20], mem_model[16'h20]); else passed++;
  endtask

  task automatic test_hold_req();
    bit seq [$];
    logic [15:0] xa, xb;
    do_reset();
    xa = 16'h0033; xb = 16'h0044;
    drv0(0, 1, 0, xa, '0);
    for (int c = 0; c < 40 && seq.size() < 3; c++) begin
      @(negedge CLK);
      if (if0.A_Ack) begin
        seq.push_back(0);
        total++; if (if0.A_RData !== mem_model[xa[7:0]]) $display("FAIL hold_a_data: got %0h expected %0h", if0.A_RData, mem_model[xa[7:0]]); else passed++;
        if (seq.size() == 1) drv0(1, 1, 0, xb, '0);
        else drv0(0, 0, 0, '0, '0);
      end else if (if0.B_Ack) begin
        seq.push_back(1);
        total++; if (if0.B_RData !== mem_model[xb[7:0]]) $display("FAIL hold_b_data: got %0h expected %0h", if0.B_RData, mem_model[xb[7:0]]); else passed++;
        drv0(1, 0, 0, '0, '0);
      end
    end
    total++; if (seq.size() != 3) $display("FAIL hold_count: got %0d expected 3", seq.size()); else passed++;
    if (seq.size() == 3) begin
      total++; if ({seq[0], seq[1], seq[2]} !== 3'b010) $display("FAIL hold_order: got %0b expected 010", {seq[0], seq[1], seq[2]}); else passed++;
    end
    drv0(0, 0, 0, '0, '0); drv0(1, 0, 0, '0, '0);
    repeat (3) @(negedge CLK);
  endtask

  // One requester issuing n random transactions; data checked against mem_model.
  task automatic rand_port(input bit pb, input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [15:0] a, d;
      logic w;
      bit got = 0;
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 16'h0100 + 16'($urandom_range(0, 255));
      else if (r == 1) a = 16'($urandom);
      else a = 16'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      drv0(pb, 1, w, a, d);
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge CLK);
        if (pb ? if0.B_Ack : if0.A_Ack) begin
          logic [15:0] rd, exp_rd;
          logic        er;
          bit          oor;
          got = 1;
          rd  = pb ? if0.B_RData : if0.A_RData;
          er  = pb ? if0.B_Err : if0.A_Err;
          oor = (a >= 16'd256);
          exp_rd = (oor || w) ? 16'h0 : mem_model[a[7:0]];
          if (!oor && w) mem_model[a[7:0]] = d;
          total++; if (er !== oor) $display("FAIL rnd_err port%0d: got %0h expected %0h", pb, er, oor); else passed++;
          total++; if (rd !== exp_rd) $display("FAIL rnd_rdata port%0d: got %0h expected %0h", pb, rd, exp_rd); else passed++;
          total++; if (if0.A_Ack && if0.B_Ack) $display("FAIL rnd_excl: got both acks expected one"); else passed++;
        end
      end
      if (!got) begin total++; $display("FAIL rnd_timeout port%0d: got no ack expected ack", pb); end
      drv0(pb, 0, 0, '0, '0);
      repeat (int'($urandom_range(0, 2))) @(negedge CLK);
    end
  endtask

  task automatic test_random();
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 256; i++) begin
      total++; if (ram0[i] !== mem_model[i]) $display("FAIL rnd_final_mem[%0d]: got %0h expected %0h", i, ram0[i], mem_model[i]); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'(i * 257 + 3);
      ram1[i] = 16'(i * 31 + 7);
      mem_model[i] = 16'(i * 257 + 3);
    end
    test_reset();
    test_write_read();
    test_round_robin();
    test_prio();
    test_out_of_range();
    test_reset_mid_write();
    test_hold_req();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
